// File: rtl/b03_pkg.sv
// Shared definitions for the b03 requester: client/bit mapping, agent states
// and the arbiter queue codes used by benches that mirror the arbiter.
package b03_pkg;

    localparam int NUM_CLIENTS = 4;

    localparam int CLIENT1 = 1;
    localparam int CLIENT2 = 2;
    localparam int CLIENT3 = 3;
    localparam int CLIENT4 = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } agent_state_t;

    localparam logic [2:0] QUEUE_U1 = 3'b100;
    localparam logic [2:0] QUEUE_U2 = 3'b010;
    localparam logic [2:0] QUEUE_U3 = 3'b001;
    localparam logic [2:0] QUEUE_U4 = 3'b111;

    // Client n lives on bit 4-n of every 4-bit vector (client1 is the MSB).
    function automatic int client_bit(input int client);
        return NUM_CLIENTS - client;
    endfunction

endpackage

// File: rtl/b03_req_agent.sv
// One client's pending-job counter and IDLE/REQ/GAP request FSM.
// Optional starvation watchdog is built only when B03_REQ_STARVE_EN is defined.
module b03_req_agent
    import b03_pkg::*;
#(
    parameter int CNT_W     = 3,
    parameter int GRANT_LAT = 4,
    parameter int GAP       = 2,
    parameter int TIMEOUT   = 32
) (
    input  logic clock,
    input  logic reset,
    input  logic job,
    input  logic grant,
    output logic request,
    output logic served,
    output logic overflow,
    output logic starve
);

    localparam int HOLD_W = $clog2(GRANT_LAT + 2);
    localparam int GAP_W  = $clog2(GAP + 1);

    localparam logic [CNT_W-1:0]  PEND_MAX = {CNT_W{1'b1}};
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(GRANT_LAT);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP - 1);

    if (GRANT_LAT < 1 || GAP < 1 || TIMEOUT < 2) begin : g_bad_param
        $error("b03_req_agent: GRANT_LAT and GAP must be >= 1, TIMEOUT >= 2");
    end

    agent_state_t      state_reg;
    logic [CNT_W-1:0]  pending_reg;
    logic [CNT_W-1:0]  pending_next;
    logic [HOLD_W-1:0] hold_reg;
    logic [GAP_W-1:0]  gap_reg;
    logic              request_reg;
    logic              served_reg;
    logic              overflow_reg;

    logic accept;
    logic overflow_next;
    logic job_taken;
    logic req_enter;

    // A grant only counts once the request has been visible long enough for the
    // arbiter to have sampled it; earlier grant bits are leftovers.
    assign accept        = (state_reg == ST_REQ) && grant && (hold_reg >= HOLD_MAX);
    assign overflow_next = job && (pending_reg == PEND_MAX) && !accept;
    assign job_taken     = job && !overflow_next;

    always_comb begin
        pending_next = pending_reg;
        if (job_taken && !accept) begin
            pending_next = pending_reg + CNT_W'(1);
        end else if (accept && !job_taken) begin
            pending_next = pending_reg - CNT_W'(1);
        end
    end

    assign req_enter = (pending_next != '0) &&
                       ((state_reg == ST_IDLE) ||
                        ((state_reg == ST_GAP) && (gap_reg == '0)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            pending_reg  <= '0;
            hold_reg     <= '0;
            gap_reg      <= '0;
            request_reg  <= 1'b0;
            served_reg   <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            pending_reg  <= pending_next;
            served_reg   <= accept;
            overflow_reg <= overflow_next;
            case (state_reg)
                ST_IDLE: begin
                    if (req_enter) begin
                        state_reg   <= ST_REQ;
                        request_reg <= 1'b1;
                        hold_reg    <= HOLD_W'(1);
                    end
                end
                ST_REQ: begin
                    if (accept) begin
                        state_reg   <= ST_GAP;
                        request_reg <= 1'b0;
                        gap_reg     <= GAP_LAST;
                    end else if (hold_reg < HOLD_MAX) begin
                        hold_reg <= hold_reg + HOLD_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_reg != '0) begin
                        gap_reg <= gap_reg - GAP_W'(1);
                    end else if (req_enter) begin
                        state_reg   <= ST_REQ;
                        request_reg <= 1'b1;
                        hold_reg    <= HOLD_W'(1);
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    request_reg <= 1'b0;
                end
            endcase
        end
    end

    assign request  = request_reg;
    assign served   = served_reg;
    assign overflow = overflow_reg;

`ifdef B03_REQ_STARVE_EN
    localparam int WD_W = $clog2(TIMEOUT + 2);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_TRIP = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd_reg;
    logic            starve_reg;

    // wd_reg holds the number of REQ cycles so far including the current one;
    // the flag is set on the edge that starts REQ cycle TIMEOUT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_reg     <= '0;
            starve_reg <= 1'b0;
        end else if (req_enter) begin
            wd_reg <= WD_W'(1);
        end else if ((state_reg == ST_REQ) && !accept) begin
            if (wd_reg < WD_MAX) begin
                wd_reg <= wd_reg + WD_W'(1);
            end
            if (wd_reg >= WD_TRIP) begin
                starve_reg <= 1'b1;
            end
        end
    end

    assign starve = starve_reg;
`else
    assign starve = 1'b0;
`endif

endmodule

// File: rtl/b03_requester.sv
// Four-client requester for the b03 round-robin arbiter: one agent per client.
// Starvation flags are live only when B03_REQ_STARVE_EN is defined.
module b03_requester
    import b03_pkg::*;
#(
    parameter int CNT_W     = 3,
    parameter int GRANT_LAT = 4,
    parameter int GAP       = 2,
    parameter int TIMEOUT   = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] job_i,
    input  logic [3:0] grant_i,
    output logic       request1,
    output logic       request2,
    output logic       request3,
    output logic       request4,
    output logic [3:0] served_o,
    output logic [3:0] overflow_o,
    output logic [3:0] starve_o
);

    logic [NUM_CLIENTS-1:0] request_vec;

    // Agent gi serves the client whose bit is gi, i.e. client 4-gi.
    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_agent
        b03_req_agent #(
            .CNT_W     (CNT_W),
            .GRANT_LAT (GRANT_LAT),
            .GAP       (GAP),
            .TIMEOUT   (TIMEOUT)
        ) u_agent (
            .clock    (clock),
            .reset    (reset),
            .job      (job_i[gi]),
            .grant    (grant_i[gi]),
            .request  (request_vec[gi]),
            .served   (served_o[gi]),
            .overflow (overflow_o[gi]),
            .starve   (starve_o[gi])
        );
    end

    assign request1 = request_vec[client_bit(CLIENT1)];
    assign request2 = request_vec[client_bit(CLIENT2)];
    assign request3 = request_vec[client_bit(CLIENT3)];
    assign request4 = request_vec[client_bit(CLIENT4)];

endmodule

// File: tb/tb_b03_requester.sv
// Directed bench for b03_requester: a per-client event model checked every cycle,
// plus literal expectations taken from the intended timing.
module tb_b03_requester;

    localparam int GRANT_LAT = 4;
    localparam int GAP       = 2;
    localparam int TIMEOUT   = 32;
    localparam int PEND_MAX  = 7;
`ifdef B03_REQ_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic [3:0] job_i;
    logic [3:0] grant_i;
    logic       request1, request2, request3, request4;
    logic [3:0] served_o, overflow_o, starve_o;
    logic [3:0] req_vec;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    b03_requester dut (
        .clock      (clock),
        .reset      (reset),
        .job_i      (job_i),
        .grant_i    (grant_i),
        .request1   (request1),
        .request2   (request2),
        .request3   (request3),
        .request4   (request4),
        .served_o   (served_o),
        .overflow_o (overflow_o),
        .starve_o   (starve_o)
    );

    assign req_vec = {request1, request2, request3, request4};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    // Model: per client a pending count, the age of the current request
    // (0 = not requesting) and the number of forced-low cycles still owed.
    int         m_pend  [4];
    int         m_age   [4];
    int         m_quiet [4];
    logic [3:0] exp_req, exp_served, exp_ovf, exp_starve;

    task automatic model_clear();
        for (int b = 0; b < 4; b++) begin
            m_pend[b]  = 0;
            m_age[b]   = 0;
            m_quiet[b] = 0;
        end
        exp_req    = 4'b0;
        exp_served = 4'b0;
        exp_ovf    = 4'b0;
        exp_starve = 4'b0;
    endtask

    task automatic model_step(input logic [3:0] j, input logic [3:0] g);
        for (int b = 0; b < 4; b++) begin
            bit acc;
            bit ovf;
            int pn;
            acc = (m_age[b] >= GRANT_LAT) && g[b];
            ovf = j[b] && (m_pend[b] == PEND_MAX) && !acc;
            pn  = m_pend[b] + ((j[b] && !ovf) ? 1 : 0) - (acc ? 1 : 0);
            exp_served[b] = acc;
            exp_ovf[b]    = ovf;
            if (m_age[b] > 0) begin
                if (acc) begin
                    m_age[b]   = 0;
                    m_quiet[b] = GAP;
                end else begin
                    m_age[b] = m_age[b] + 1;
                    if (STARVE_ON && m_age[b] >= TIMEOUT) exp_starve[b] = 1'b1;
                end
            end else if (m_quiet[b] > 0) begin
                m_quiet[b] = m_quiet[b] - 1;
                if (m_quiet[b] == 0 && pn > 0) m_age[b] = 1;
            end else if (pn > 0) begin
                m_age[b] = 1;
            end
            m_pend[b]  = pn;
            exp_req[b] = (m_age[b] > 0);
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clock or posedge reset);
            if (reset) model_clear();
            else model_step(job_i, grant_i);
        end
    end

    always @(negedge clock) begin
        if (check_en && !reset) begin
            chk("cycle_request",  {28'b0, req_vec},    {28'b0, exp_req});
            chk("cycle_served",   {28'b0, served_o},   {28'b0, exp_served});
            chk("cycle_overflow", {28'b0, overflow_o}, {28'b0, exp_ovf});
            chk("cycle_starve",   {28'b0, starve_o},   {28'b0, exp_starve});
        end
    end

    // One cycle of stimulus; returns at the following falling edge.
    task automatic tick(input logic [3:0] j, input logic [3:0] g);
        @(posedge clock);
        #1;
        job_i   = j;
        grant_i = g;
        @(negedge clock);
    endtask

    task automatic run(input int n, input logic [3:0] g, input int b,
                       output int served_cnt, output int ovf_cnt);
        served_cnt = 0;
        ovf_cnt    = 0;
        for (int i = 0; i < n; i++) begin
            tick(4'b0000, g);
            served_cnt += served_o[b];
            ovf_cnt    += overflow_o[b];
        end
    endtask

    int s_cnt, o_cnt, early, ovf_total, srv_total;

    initial begin
        reset   = 1'b1;
        job_i   = 4'b0;
        grant_i = 4'b0;
        repeat (3) @(negedge clock);
        chk("reset_request",  {28'b0, req_vec},    0);
        chk("reset_served",   {28'b0, served_o},   0);
        chk("reset_overflow", {28'b0, overflow_o}, 0);
        chk("reset_starve",   {28'b0, starve_o},   0);
        #1 reset = 1'b0;
        check_en = 1'b1;
        repeat (2) tick(4'b0000, 4'b0000);

        // Single job on client1, grant from the fourth request cycle.
        tick(4'b1000, 4'b0000);
        chk("a_req_t0", request1, 0);
        tick(4'b0000, 4'b0000);
        chk("a_req_t1", request1, 1);
        tick(4'b0000, 4'b0000);
        tick(4'b0000, 4'b0000);
        tick(4'b0000, 4'b1000);
        chk("a_req_t4", request1, 1);
        chk("a_served_t4", {28'b0, served_o}, 0);
        tick(4'b0000, 4'b1000);
        chk("a_served_t5", {28'b0, served_o}, 32'h8);
        chk("a_req_t5", request1, 0);
        tick(4'b0000, 4'b0000);
        chk("a_req_t6", request1, 0);
        tick(4'b0000, 4'b0000);
        chk("a_req_t7", request1, 0);
        repeat (3) tick(4'b0000, 4'b0000);

        // Stale grant on client2 held before its job arrives.
        tick(4'b0000, 4'b0100);
        tick(4'b0000, 4'b0100);
        tick(4'b0100, 4'b0100);
        run(4, 4'b0100, 2, early, o_cnt);
        chk("b_early_served", early, 0);
        run(12, 4'b0100, 2, s_cnt, o_cnt);
        chk("b_served_once", s_cnt, 1);
        chk("b_req_final", request2, 0);
        tick(4'b0000, 4'b0000);

        // Three consecutive jobs on client3.
        tick(4'b0010, 4'b0010);
        tick(4'b0010, 4'b0010);
        tick(4'b0010, 4'b0010);
        run(30, 4'b0010, 1, s_cnt, o_cnt);
        chk("c_served_three", s_cnt, 3);
        chk("c_req_final", request3, 0);
        tick(4'b0000, 4'b0000);

        // Eight jobs on client4 with no grant: saturate at 7, one overflow.
        ovf_total = 0;
        for (int i = 0; i < 8; i++) begin
            tick(4'b0001, 4'b0000);
            ovf_total += overflow_o[0];
        end
        run(40, 4'b0000, 0, s_cnt, o_cnt);
        ovf_total += o_cnt;
        chk("d_overflow_once", ovf_total, 1);
        chk("d_starve", {28'b0, starve_o}, STARVE_ON ? 32'h1 : 32'h0);
        run(50, 4'b0001, 0, s_cnt, o_cnt);
        chk("d_drain_seven", s_cnt, 7);
        chk("d_req_final", request4, 0);
        tick(4'b0000, 4'b0000);

        // Client1 full, job and accept in the same cycle.
        ovf_total = 0;
        for (int i = 0; i < 7; i++) begin
            tick(4'b1000, 4'b0000);
            ovf_total += overflow_o[3];
        end
        tick(4'b1000, 4'b1000);
        ovf_total += overflow_o[3];
        tick(4'b0000, 4'b1000);
        chk("e_no_overflow", {28'b0, overflow_o}, 0);
        chk("e_served", {28'b0, served_o}, 32'h8);
        srv_total = 1;
        run(60, 4'b1000, 3, s_cnt, o_cnt);
        srv_total += s_cnt;
        ovf_total += o_cnt;
        chk("e_served_total", srv_total, 8);
        chk("e_overflow_total", ovf_total, 0);
        tick(4'b0000, 4'b0000);

        // Asynchronous reset while client1 requests with two jobs pending.
        tick(4'b1000, 4'b0000);
        tick(4'b1000, 4'b0000);
        tick(4'b0000, 4'b0000);
        tick(4'b0000, 4'b0000);
        chk("f_req_before", request1, 1);
        @(posedge clock);
        #2;
        reset   = 1'b1;
        job_i   = 4'b0;
        grant_i = 4'b0;
        #1;
        chk("f_reset_request", {28'b0, req_vec},    0);
        chk("f_reset_served",  {28'b0, served_o},   0);
        chk("f_reset_starve",  {28'b0, starve_o},   0);
        @(negedge clock);
        #1 reset = 1'b0;
        tick(4'b1000, 4'b1000);
        run(16, 4'b1000, 3, s_cnt, o_cnt);
        chk("f_served_once", s_cnt, 1);
        chk("f_req_final", request1, 0);
        tick(4'b0000, 4'b0000);

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
